button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Conditions a raw, asynchronous push-button input into a clean, glitch-free level for the digital clock's set and adjust buttons.
- Uses a 2-flop synchronizer, a 4-state qualification FSM and a stability counter.
- Sits directly upstream of the rising-edge pulse stage. btn_out feeds that stage's w input, so each physical press produces exactly one z pulse downstream.

Parameters:
- STABLE_CYCLES, 1000000, number of consecutive clk cycles the synchronized input must hold a new level before btn_out follows (10 ms at 100 MHz). Legal range 2 .. 2^CNT_W-1.
- CNT_W, 20, width of the stability counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset: one clock; reset is asynchronous and active-low (rst=0 resets).
- btn_in  input  1  raw button level; asynchronous to clk; may bounce.
- btn_out  output  1  debounced level; registered; drives the downstream edge detector.
- settling  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release by clk):
  - sync1=0, sync2=0, state=LOW, cnt=0, btn_out=0, settling=0.
  - Takes effect immediately and holds while rst=0, even mid-qualification or with the button held.
- Synchronizer:
  - sync1<=btn_in; sync2<=sync1; btn_sync=sync2.
  - No logic other than sync1 reads btn_in.
- FSM states: LOW, WAIT_H, HIGH, WAIT_L.
  - LOW: if btn_sync=1, go to WAIT_H with cnt<=0; else stay.
  - WAIT_H:
    - If btn_sync=0, go to LOW with cnt<=0 (glitch rejected).
    - Else if cnt==STABLE_CYCLES-1, go to HIGH with cnt<=0.
    - Else cnt<=cnt+1.
  - HIGH: if btn_sync=0, go to WAIT_L with cnt<=0; else stay.
  - WAIT_L: mirror of WAIT_H with levels inverted. Qualification completes into LOW; a revert returns to HIGH.
  - Unreachable encodings go to LOW with cnt=0.
- Outputs:
  - btn_out and settling are registered, updated on the same edge as state.
  - btn_out=1 exactly when the next state is HIGH or WAIT_L.
  - settling=1 exactly when the next state is WAIT_H or WAIT_L.
- Latency:
  - btn_in stable high, first sampled at edge E0.
  - sync2=1 after E1; WAIT_H entered at E2; btn_out=1 at edge E(2+STABLE_CYCLES).
  - Release latency is identical.
- Counter:
  - Never exceeds STABLE_CYCLES-1 and never wraps.
  - Holds 0 in LOW and HIGH.
- Glitches:
  - A btn_sync excursion lasting ≤ STABLE_CYCLES cycles, counted from WAIT entry, never changes btn_out.
  - Any revert restarts qualification from cnt=0 on the next excursion.
- Simultaneous events:
  - A revert on the exact cycle cnt==STABLE_CYCLES-1 wins: the FSM returns to the prior stable state and btn_out is unchanged.
- No combinational path from btn_in to any output.

Test Plan:
(All with STABLE_CYCLES=4, CNT_W=3.)
1. Reset:
   - Stimulus: rst=0 for 3 cycles with btn_in=1, then release.
   - Response: btn_out=0 and settling=0 throughout reset; btn_out rises exactly 6 clk edges after the first post-release edge that samples btn_in=1.
2. Clean press and release:
   - Stimulus: btn_in 0→1 held 20 cycles, then 1→0.
   - Response: settling high for 4 cycles; btn_out=1 on the 6th edge after the rise; btn_out=0 on the 6th edge after the fall. Downstream edge detector emits exactly one z pulse.
3. Bounce:
   - Stimulus: btn_in toggles 1,0,1,0,1 at 1-cycle intervals, then holds 1.
   - Response: btn_out stays 0 during the toggling; settling deasserts on each revert. btn_out=1 six edges after the final rise; no btn_out glitches.
4. Revert at terminal count:
   - Stimulus: btn_sync=1 for exactly 4 cycles of WAIT_H, with the revert landing on the cnt==3 cycle.
   - Response: FSM returns to LOW; btn_out never asserts; cnt=0.
5. Mid-qualification reset:
   - Stimulus: assert rst=0 asynchronously between edges while in WAIT_L with btn_out=1.
   - Response: btn_out, settling and cnt go to 0 immediately without a clk edge; state=LOW.
6. Long hold:
   - Stimulus: btn_in=1 for 50 cycles.
   - Response: cnt saturates at 0 in HIGH (no wrap); btn_out stays 1 continuously.

Source files
------------

// File: rtl/button_debouncer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_debouncer_if
//  Purpose  : Signal bundle between a raw push-button source and the
//             debouncer that conditions it.
//  Signals  : btn_in   - raw, asynchronous, possibly bouncing button level
//             btn_out  - debounced, registered button level
//             settling - high while a candidate level change is qualified
//  Modports : master - drives btn_in, observes btn_out / settling
//             slave  - the debouncer: consumes btn_in, drives the outputs
//  Revision : 1.0 - initial release
// ============================================================================
interface button_debouncer_if;
   logic btn_in;
   logic btn_out;
   logic settling;

   modport master (
      output btn_in,
      input  btn_out,
      input  settling
   );

   modport slave (
      input  btn_in,
      output btn_out,
      output settling
   );
endinterface : button_debouncer_if
`default_nettype wire

// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : Turns a raw push-button level into a clean, glitch-free level.
//             The raw input passes through a 2-flop synchronizer, then a
//             4-state qualification FSM requires the synchronized level to
//             hold a new value for STABLE_CYCLES consecutive cycles before
//             btn_out follows it.
//  Ports    : clk          - system clock, all state updates on posedge
//             rst          - asynchronous, active-low reset (0 = reset)
//             bus.btn_in   - raw button level, asynchronous to clk
//             bus.btn_out  - debounced level (registered)
//             bus.settling - high while a level change is being qualified
//  Params   : STABLE_CYCLES - qualification length in clk cycles
//                             (legal range 2 .. 2**CNT_W-1)
//             CNT_W         - width of the stability counter
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned CNT_W         = 20
) (
   input  wire                 clk,
   input  wire                 rst,
   button_debouncer_if.slave   bus
);

   // Terminal count: the WAIT state has seen the new level for STABLE_CYCLES
   // cycles when the counter reaches this value and the level still holds.
   localparam logic [CNT_W-1:0] c_last = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_WAIT_H = 2'd1,
      ST_HIGH   = 2'd2,
      ST_WAIT_L = 2'd3
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_btn_out;
   logic             r_settling;
   logic             w_btn_sync;

   assign w_btn_sync   = r_sync2;
   assign bus.btn_out  = r_btn_out;
   assign bus.settling = r_settling;

   // -------------------------------------------------------------------------
   // Synchronizer and qualification FSM. btn_out / settling are loaded with
   // the values that correspond to the state being entered, so they are
   // registered and change on the same edge as the state.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_state    <= ST_LOW;
         r_cnt      <= '0;
         r_btn_out  <= 1'b0;
         r_settling <= 1'b0;
      end else begin
         // Only r_sync1 ever looks at the raw asynchronous input.
         r_sync1 <= bus.btn_in;
         r_sync2 <= r_sync1;

         case (r_state)
            ST_LOW: begin
               r_cnt     <= '0;
               r_btn_out <= 1'b0;
               if (w_btn_sync) begin
                  r_state    <= ST_WAIT_H;
                  r_settling <= 1'b1;
               end else begin
                  r_state    <= ST_LOW;
                  r_settling <= 1'b0;
               end
            end

            ST_WAIT_H: begin
               if (!w_btn_sync) begin
                  // Revert has priority over the terminal count.
                  r_state    <= ST_LOW;
                  r_cnt      <= '0;
                  r_btn_out  <= 1'b0;
                  r_settling <= 1'b0;
               end else if (r_cnt == c_last) begin
                  r_state    <= ST_HIGH;
                  r_cnt      <= '0;
                  r_btn_out  <= 1'b1;
                  r_settling <= 1'b0;
               end else begin
                  r_state    <= ST_WAIT_H;
                  r_cnt      <= r_cnt + c_one;
                  r_btn_out  <= 1'b0;
                  r_settling <= 1'b1;
               end
            end

            ST_HIGH: begin
               r_cnt     <= '0;
               r_btn_out <= 1'b1;
               if (!w_btn_sync) begin
                  r_state    <= ST_WAIT_L;
                  r_settling <= 1'b1;
               end else begin
                  r_state    <= ST_HIGH;
                  r_settling <= 1'b0;
               end
            end

            ST_WAIT_L: begin
               if (w_btn_sync) begin
                  // Level came back high before qualifying: stay pressed.
                  r_state    <= ST_HIGH;
                  r_cnt      <= '0;
                  r_btn_out  <= 1'b1;
                  r_settling <= 1'b0;
               end else if (r_cnt == c_last) begin
                  r_state    <= ST_LOW;
                  r_cnt      <= '0;
                  r_btn_out  <= 1'b0;
                  r_settling <= 1'b0;
               end else begin
                  r_state    <= ST_WAIT_L;
                  r_cnt      <= r_cnt + c_one;
                  r_btn_out  <= 1'b1;
                  r_settling <= 1'b1;
               end
            end

            default: begin
               r_state    <= ST_LOW;
               r_cnt      <= '0;
               r_btn_out  <= 1'b0;
               r_settling <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Structural invariants of the counter and outputs.
   // -------------------------------------------------------------------------
   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
      r_cnt <= c_last);

   a_cnt_idle : assert property (@(posedge clk) disable iff (!rst)
      ((r_state == ST_LOW) || (r_state == ST_HIGH)) |-> (r_cnt == '0));

   a_out_match : assert property (@(posedge clk) disable iff (!rst)
      r_btn_out == ((r_state == ST_HIGH) || (r_state == ST_WAIT_L)));

   a_settle_match : assert property (@(posedge clk) disable iff (!rst)
      r_settling == ((r_state == ST_WAIT_H) || (r_state == ST_WAIT_L)));

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_button_debouncer
//  Purpose  : Scoreboard bench for button_debouncer (STABLE_CYCLES=4,
//             CNT_W=3). Stimulus pushes the reference model's expected
//             outputs into a queue; a monitor pops them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

   localparam int STABLE = 4;

   logic clk;
   logic rst;

   button_debouncer_if bus ();

   button_debouncer #(
      .STABLE_CYCLES (STABLE),
      .CNT_W         (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rise  = 0;
   logic prev_out = 1'b0;

   logic [1:0] exp_q [$];   // {btn_out, settling}

   // Reference model: the output level flips once the level seen by the
   // qualifier has differed from it on STABLE+1 consecutive edges (one edge
   // to notice the change plus STABLE edges of holding). The qualifier sees
   // btn_in two edges late.
   logic m_h1, m_h2, m_d;
   int   m_run;

   task automatic model_reset();
      m_h1  = 1'b0;
      m_h2  = 1'b0;
      m_d   = 1'b0;
      m_run = 0;
   endtask

   task automatic model_edge(input logic b, input logic r);
      logic s;
      if (!r) begin
         model_reset();
      end else begin
         s    = m_h2;
         m_h2 = m_h1;
         m_h1 = b;
         if (s != m_d) m_run = m_run + 1;
         else          m_run = 0;
         if (m_run == STABLE + 1) begin
            m_d   = ~m_d;
            m_run = 0;
         end
      end
      exp_q.push_back({m_d, (m_run != 0)});
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus: drive, let the DUT sample, record expectation,
   // then park just after the falling edge (after the monitor has run).
   task automatic step(input logic b);
      bus.btn_in = b;
      @(posedge clk);
      model_edge(b, rst);
      @(negedge clk);
      #1;
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   // Monitor
   always @(negedge clk) begin
      logic [1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("btn_out",  bus.btn_out,  e[1]);
         check("settling", bus.settling, e[0]);
         if (bus.btn_out && !prev_out) n_rise = n_rise + 1;
         prev_out = bus.btn_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   initial begin
      model_reset();
      rst        = 1'b0;
      bus.btn_in = 1'b0;
      @(negedge clk);
      #1;

      // 1. Reset held with button pressed, then release.
      hold(1'b1, 3);
      rst = 1'b1;
      hold(1'b1, 10);
      hold(1'b0, 12);

      // 2. Clean press and release: one rise of btn_out.
      n_rise = 0;
      hold(1'b1, 20);
      hold(1'b0, 12);
      check("clean_press_rises", (n_rise == 1), 1'b1);

      // 3. Bounce then settle high.
      n_rise = 0;
      step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
      hold(1'b1, 10);
      hold(1'b0, 12);
      check("bounce_rises", (n_rise == 1), 1'b1);

      // 4. Revert landing on terminal count: four synced-high cycles.
      n_rise = 0;
      hold(1'b1, STABLE);
      hold(1'b0, 10);
      check("terminal_revert_rises", (n_rise == 0), 1'b1);

      // 5. Asynchronous reset while qualifying a release.
      hold(1'b1, 10);
      hold(1'b0, 3);
      check("pre_reset_btn_out",  bus.btn_out,  m_d);
      check("pre_reset_settling", bus.settling, (m_run != 0));
      rst = 1'b0;
      #1;
      model_reset();
      check("async_rst_btn_out",  bus.btn_out,  1'b0);
      check("async_rst_settling", bus.settling, 1'b0);
      @(negedge clk);
      #1;
      hold(1'b0, 2);
      rst = 1'b1;
      hold(1'b0, 4);

      // 6. Long hold.
      n_rise = 0;
      hold(1'b1, 50);
      hold(1'b0, 12);
      check("long_hold_rises", (n_rise == 1), 1'b1);

      // 7. Randomized runs of random level and length.
      for (int i = 0; i < 60; i++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 8));
         hold(lvl, len);
      end
      hold(1'b0, 12);

      @(negedge clk);
      #1;
      check("queue_drained", (exp_q.size() == 0), 1'b1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_button_debouncer
`default_nettype wire
